// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (port 0) and a
// FIFO-buffered multi-cycle unit writeback (port 1). Optional anti-starvation: WB_ARB_STARVE_EN.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p0_valid,
    output logic                          p0_ready,
    input  logic [ADDR_WIDTH-1:0]         p0_addr,
    input  logic [DATA_WIDTH-1:0]         p0_data,
    input  logic                          p1_valid,
    output logic                          p1_ready,
    input  logic [ADDR_WIDTH-1:0]         p1_addr,
    input  logic [DATA_WIDTH-1:0]         p1_data,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [2**ADDR_WIDTH-1:0]      pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          starve_force
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [CNT_W-1:0]      count_q;

    logic                  fifo_nonempty;
    logic                  push;
    logic                  head_issue;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign fifo_nonempty = (count_q != '0);
    // No look-ahead: a pop on a full FIFO frees the slot only from the next cycle.
    assign p1_ready      = (count_q < CNT_W'(FIFO_DEPTH));
    assign push          = p1_valid && p1_ready;
    assign head_issue    = starve_force || (!p0_valid && fifo_nonempty);
    assign issue         = head_issue || p0_valid;
    assign sel_addr      = head_issue ? addr_q[head_ptr] : p0_addr;
    assign sel_data      = head_issue ? data_q[head_ptr] : p0_data;
    assign fifo_count    = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_ptr] <= p1_addr;
            data_q[tail_ptr] <= p1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count_q    <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                tail_ptr             <= tail_ptr + PTR_W'(1);
                slot_valid[tail_ptr] <= 1'b1;
            end
            if (head_issue) begin
                head_ptr             <= head_ptr + PTR_W'(1);
                slot_valid[head_ptr] <= 1'b0;
            end
            unique case ({push, head_issue})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (issue) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i]) begin
                pend_mask[addr_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

`ifdef WB_ARB_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!fifo_nonempty || head_issue) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign starve_force = fifo_nonempty && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign p0_ready     = !starve_force;
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign starve_force = 1'b0;
    assign p0_ready     = 1'b1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: queue-based reference model checked every negedge,
// plus literal expectations. Follows WB_ARB_STARVE_EN the same way as the design.
module tb_regfile_wb_arbiter;

    localparam int ADDR_WIDTH   = 5;
    localparam int DATA_WIDTH   = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        p0_valid = 1'b0;
    logic [ADDR_WIDTH-1:0]       p0_addr = '0;
    logic [DATA_WIDTH-1:0]       p0_data = '0;
    logic                        p1_valid = 1'b0;
    logic [ADDR_WIDTH-1:0]       p1_addr = '0;
    logic [DATA_WIDTH-1:0]       p1_data = '0;
    logic                        p0_ready;
    logic                        p1_ready;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [2**ADDR_WIDTH-1:0]    pend_mask;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        starve_force;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_mask(pend_mask), .fifo_count(fifo_count), .starve_force(starve_force)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending port-1 writes and a head wait counter.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
    } ent_t;

    ent_t                  mq[$];
    int                    m_wait    = 0;
    logic                  m_wr_en   = 1'b0;
    logic [ADDR_WIDTH-1:0] m_wr_addr = '0;
    logic [DATA_WIDTH-1:0] m_wr_data = '0;

    function automatic bit m_force();
        return STARVE_ON && (m_wait == STARVE_LIMIT) && (mq.size() > 0);
    endfunction

    function automatic logic [2**ADDR_WIDTH-1:0] m_pend();
        logic [2**ADDR_WIDTH-1:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit   ne, frc, rdy, take_head;
        ent_t sel;
        if (rst) begin
            mq.delete();
            m_wait    = 0;
            m_wr_en   = 1'b0;
            m_wr_addr = '0;
            m_wr_data = '0;
        end else begin
            ne        = mq.size() > 0;
            frc       = m_force();
            rdy       = mq.size() < FIFO_DEPTH;
            take_head = frc || (!p0_valid && ne);
            sel       = take_head ? mq[0] : {p0_addr, p0_data};
            if (take_head || p0_valid) begin
                m_wr_en   = (sel.a != 0);
                m_wr_addr = sel.a;
                m_wr_data = sel.d;
            end else begin
                m_wr_en = 1'b0;
            end
            if (take_head) begin
                void'(mq.pop_front());
                m_wait = 0;
            end else if (ne) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
            if (p1_valid && rdy) mq.push_back({p1_addr, p1_data});
        end
    end

    always @(negedge clk) begin
        check("cmp_wr_en",        wr_en,        m_wr_en);
        check("cmp_wr_addr",      wr_addr,      m_wr_addr);
        check("cmp_wr_data",      wr_data,      m_wr_data);
        check("cmp_fifo_count",   fifo_count,   mq.size());
        check("cmp_pend_mask",    pend_mask,    m_pend());
        check("cmp_p1_ready",     p1_ready,     mq.size() < FIFO_DEPTH);
        check("cmp_starve_force", starve_force, m_force());
        check("cmp_p0_ready",     p0_ready,     !m_force());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  pushed;
        bit  acc;

        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_pend_mask", pend_mask, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_starve_force", starve_force, 0);
        check("rst_p1_ready", p1_ready, 1);
        check("rst_p0_ready", p0_ready, 1);

        // Port 0 write
        p0_valid = 1'b1; p0_addr = 5; p0_data = 32'hDEADBEEF;
        check("p0_ready_w5", p0_ready, 1);
        step();
        p0_valid = 1'b0;
        check("p0_wr_en", wr_en, 1);
        check("p0_wr_addr", wr_addr, 5);
        check("p0_wr_data", wr_data, 32'hDEADBEEF);
        step();
        check("idle_wr_en", wr_en, 0);
        check("idle_wr_addr_hold", wr_addr, 5);

        // Port 1 single push, minimum latency
        p1_valid = 1'b1; p1_addr = 7; p1_data = 32'h11;
        step();
        p1_valid = 1'b0;
        check("p1_pend_bit7", pend_mask, 32'h80);
        check("p1_count1", fifo_count, 1);
        check("p1_no_bypass", wr_en, 0);
        check("model_count1", mq.size(), 1);
        step();
        check("p1_wr_en", wr_en, 1);
        check("p1_wr_addr", wr_addr, 7);
        check("p1_wr_data", wr_data, 32'h11);
        check("p1_pend_clear", pend_mask, 0);
        step();

        // Three back-to-back port-1 pushes under continuous port-0 traffic
        p0_valid = 1'b1; p0_addr = 10; p0_data = 32'hA0A0;
        pushed = 0;
        for (int c = 0; c < 8; c++) begin
            p1_valid = (pushed < 3);
            p1_addr  = ADDR_WIDTH'(20 + pushed);
            p1_data  = 32'h100 + pushed;
            acc      = p1_valid && p1_ready;
            step();
            if (acc) pushed++;
            if (c == 1) begin
                check("full_p1_ready", p1_ready, 0);
                check("full_count", fifo_count, 2);
            end
`ifdef WB_ARB_STARVE_EN
            if (c == 4) begin
                check("starve_force_on", starve_force, 1);
                check("starve_p0_ready", p0_ready, 0);
                check("model_force", m_force(), 1);
            end
            if (c == 5) begin
                check("starve_head_addr", wr_addr, 20);
                check("starve_head_en", wr_en, 1);
                check("starve_force_off", starve_force, 0);
            end
`else
            check("strict_p0_ready", p0_ready, 1);
            check("strict_wr_addr", wr_addr, 10);
            if (c >= 1) check("strict_full", fifo_count, 2);
`endif
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (6) step();
        check("drain_empty", fifo_count, 0);
        check("model_drain_empty", mq.size(), 0);

        // Writes to x0
        p0_valid = 1'b1; p0_addr = 0; p0_data = 32'hFFFF;
        check("x0_p0_ready", p0_ready, 1);
        step();
        p0_valid = 1'b0;
        check("x0_p0_wr_en", wr_en, 0);
        p1_valid = 1'b1; p1_addr = 0; p1_data = 32'h55;
        step();
        p1_valid = 1'b0;
        check("x0_p1_count1", fifo_count, 1);
        check("x0_p1_pend", pend_mask, 0);
        step();
        check("x0_p1_count0", fifo_count, 0);
        check("x0_p1_wr_en", wr_en, 0);
        step();

        // Mid-cycle reset with two entries queued
        p0_valid = 1'b1; p0_addr = 9; p0_data = 32'h99;
        p1_valid = 1'b1; p1_addr = 3; p1_data = 32'h33;
        step();
        p1_addr = 4; p1_data = 32'h44;
        step();
        p1_valid = 1'b0;
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_pend", pend_mask, 32'h18);
        check("pre_rst_wr_en", wr_en, 1);
        #2;
        rst = 1'b1; p0_valid = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_pend", pend_mask, 0);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_p1_ready", p1_ready, 1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_no_write", wr_en, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
